// File: rtl/keypad_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scan_pkg
// Purpose  : Shared definitions for the 4x4 keypad scanner: FSM state
//            encoding, special candidate codes and the row/column key map.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package keypad_scan_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t c_st_idle     = 2'd0;
    localparam state_t c_st_debounce = 2'd1;
    localparam state_t c_st_pressed  = 2'd2;
    localparam state_t c_st_release  = 2'd3;

    // Candidate from one full scan: bit 4 set marks a non-key result.
    typedef logic [4:0] cand_t;
    localparam cand_t c_cand_none  = 5'b1_0000;
    localparam cand_t c_cand_multi = 5'b1_0001;

    // Key map indexed by {row, column}:
    //   r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: 0 F E D
    localparam logic [15:0][3:0] c_key_map = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

endpackage
`default_nettype wire

// File: rtl/keypad_scan_key_decode16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_decode16
// Purpose  : Combinational decode of a 16-bit key snapshot (bit = {row,col},
//            1 = pressed) into a scan candidate.
// Ports    : i_snapshot  [15:0] in  - pressed keys of one full scan
//            o_candidate [4:0]  out - {special, code}; NONE / MULTI / key
// Revision : 1.0 - initial release
// ============================================================================
module key_decode16
    import keypad_scan_pkg::*;
(
    input  logic [15:0] i_snapshot,
    output logic [4:0]  o_candidate
);

    logic [4:0] w_count;
    logic [3:0] w_index;

    // Population count plus index of a set bit; the index only matters when
    // exactly one bit is set.
    always_comb begin
        w_count = '0;
        w_index = '0;
        for (int i = 0; i < 16; i++) begin
            if (i_snapshot[4'(i)]) begin
                w_count = w_count + 5'd1;
                w_index = 4'(i);
            end
        end
    end

    always_comb begin
        if (w_count == 5'd0) begin
            o_candidate = c_cand_none;
        end else if (w_count == 5'd1) begin
            o_candidate = {1'b0, c_key_map[w_index]};
        end else begin
            o_candidate = c_cand_multi;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Purpose  : 4x4 matrix keypad scanner. Drives active-low columns in
//            rotation, samples active-low rows, debounces whole scans and
//            emits one hex key code per accepted press.
// Ports    : orig_clk       in  - board clock
//            reset          in  - asynchronous active-high reset
//            row      [3:0] in  - row sense lines, active-low
//            col      [3:0] out - column drive, active-low, one-hot low
//            key_code [3:0] out - code of last accepted press
//            key_valid      out - one-cycle pulse on accepted press
//            key_held       out - high from press acceptance to release
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       orig_clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int c_dwell_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_cnt_w   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_dwell_w-1:0] c_dwell_last = c_dwell_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0]   c_deb_target = c_cnt_w'(DEBOUNCE_SCANS);
    localparam logic [c_cnt_w-1:0]   c_cnt_one    = c_cnt_w'(1);

    logic [3:0]           r_row_meta;
    logic [3:0]           r_row_sync;
    logic [c_dwell_w-1:0] r_dwell;
    logic [1:0]           r_col_idx;
    logic [15:0]          r_snapshot;
    logic [15:0]          w_snap_next;
    logic                 w_dwell_end;
    logic                 w_scan_done;
    cand_t                w_cand;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_next;
    logic [c_cnt_w-1:0]   w_count_inc;
    logic [3:0]           r_last;
    logic [3:0]           w_last_next;
    logic [3:0]           r_key_code;
    logic [3:0]           w_code_next;
    logic                 r_key_valid;
    logic                 w_valid_next;
    logic                 r_key_held;
    logic                 w_held_next;

    // Row synchroniser; idle (pulled-up) level out of reset.
    always_ff @(posedge orig_clk or posedge reset) begin
        if (reset) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    // Column dwell counter and rotation.
    assign w_dwell_end = (r_dwell == c_dwell_last);
    assign w_scan_done = w_dwell_end && (r_col_idx == 2'd3);
    assign col         = ~(4'b0001 << r_col_idx);

    always_ff @(posedge orig_clk or posedge reset) begin
        if (reset) begin
            r_dwell   <= '0;
            r_col_idx <= 2'd0;
        end else if (w_dwell_end) begin
            r_dwell   <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_dwell   <= r_dwell + 1'b1;
        end
    end

    // Snapshot with the current column merged in, so decode at scan_done
    // sees the column-3 capture of the same cycle.
    always_comb begin
        w_snap_next = r_snapshot;
        if (w_dwell_end) begin
            for (int r = 0; r < 4; r++) begin
                w_snap_next[{2'(r), r_col_idx}] = ~r_row_sync[2'(r)];
            end
        end
    end

    always_ff @(posedge orig_clk or posedge reset) begin
        if (reset) begin
            r_snapshot <= '0;
        end else begin
            r_snapshot <= w_snap_next;
        end
    end

    key_decode16 u_decode (
        .i_snapshot  (w_snap_next),
        .o_candidate (w_cand)
    );

    // FSM: state and output registers.
    always_ff @(posedge orig_clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_count     <= '0;
            r_last      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_last      <= w_last_next;
            r_key_code  <= w_code_next;
            r_key_valid <= w_valid_next;
            r_key_held  <= w_held_next;
        end
    end

    assign w_count_inc = r_count + 1'b1;

    // FSM: next-state logic, only advances on a completed scan.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_last_next  = r_last;
        if (w_scan_done) begin
            case (r_state)
                c_st_idle: begin
                    if (!w_cand[4]) begin
                        w_last_next = w_cand[3:0];
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_next = c_st_pressed;
                            w_count_next = '0;
                        end else begin
                            w_state_next = c_st_debounce;
                            w_count_next = c_cnt_one;
                        end
                    end
                end
                c_st_debounce: begin
                    if (w_cand[4]) begin
                        w_state_next = c_st_idle;
                        w_count_next = '0;
                    end else if (w_cand[3:0] == r_last) begin
                        if (w_count_inc == c_deb_target) begin
                            w_state_next = c_st_pressed;
                            w_count_next = '0;
                        end else begin
                            w_count_next = w_count_inc;
                        end
                    end else begin
                        // Bounce onto a different key: restart on it.
                        w_last_next  = w_cand[3:0];
                        w_count_next = c_cnt_one;
                    end
                end
                c_st_pressed: begin
                    if (w_cand == c_cand_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            w_state_next = c_st_idle;
                            w_count_next = '0;
                        end else begin
                            w_state_next = c_st_release;
                            w_count_next = c_cnt_one;
                        end
                    end
                end
                c_st_release: begin
                    if (w_cand == c_cand_none) begin
                        if (w_count_inc == c_deb_target) begin
                            w_state_next = c_st_idle;
                            w_count_next = '0;
                        end else begin
                            w_count_next = w_count_inc;
                        end
                    end else begin
                        w_state_next = c_st_pressed;
                        w_count_next = '0;
                    end
                end
                default: begin
                    w_state_next = c_st_idle;
                    w_count_next = '0;
                end
            endcase
        end
    end

    // FSM: outputs. A pulse only on entry to PRESSED from the press path;
    // returning from RELEASE is a bounce, not a new press.
    always_comb begin
        w_valid_next = ((r_state == c_st_idle) || (r_state == c_st_debounce))
                       && (w_state_next == c_st_pressed);
        w_code_next  = w_valid_next ? w_cand[3:0] : r_key_code;
        w_held_next  = (w_state_next == c_st_pressed) || (w_state_next == c_st_release);
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan
// Purpose  : Directed self-checking bench for keypad_scan with SCAN_DIV=4,
//            DEBOUNCE_SCANS=2 (full scan = 16 cycles). A keypad model pulls
//            a row low while a pressed key's column is driven low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;

    logic        orig_clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] r_keys;      // pressed keys, index {row, col}
    int          n_pass  = 0;
    int          n_total = 0;
    int          n_pulses = 0;
    int          cyc = 0;
    int          p0;

    always #5 orig_clk = ~orig_clk;

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .orig_clk  (orig_clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Matrix model
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (r_keys[{2'(r), 2'(c)}] && !col[2'(c)]) row[2'(r)] = 1'b0;
            end
        end
    end

    // Counts cycles in which key_valid was high (value before the edge).
    always @(posedge orig_clk) begin
        if (key_valid === 1'b1) n_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic go_to(input int n);
        repeat (n - cyc) @(negedge orig_clk);
        cyc = n;
    endtask

    // Reset pulse; returns at the negedge where reset drops (cycle 0).
    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge orig_clk);
        reset = 1'b0;
        cyc = 0;
        p0 = n_pulses;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        r_keys = '0;

        // 1: idle scan, no key
        do_reset();
        chk("s1_col0",  32'(col), 32'hE);
        chk("s1_code",  32'(key_code), 32'h0);
        chk("s1_valid", 32'(key_valid), 32'h0);
        chk("s1_held",  32'(key_held), 32'h0);
        go_to(4);   chk("s1_col1", 32'(col), 32'hD);
        go_to(8);   chk("s1_col2", 32'(col), 32'hB);
        go_to(12);  chk("s1_col3", 32'(col), 32'h7);
        go_to(16);  chk("s1_colwrap", 32'(col), 32'hE);
        go_to(64);
        chk("s1_pulses", 32'(n_pulses - p0), 32'd0);
        chk("s1_held_end", 32'(key_held), 32'h0);

        // 2: key r1c2 (6) held for 6 scans
        do_reset();
        r_keys = 16'h0040;
        go_to(31);  chk("s2_valid_early", 32'(key_valid), 32'h0);
        go_to(32);
        chk("s2_valid", 32'(key_valid), 32'h1);
        chk("s2_code",  32'(key_code), 32'h6);
        chk("s2_held",  32'(key_held), 32'h1);
        go_to(33);  chk("s2_valid_once", 32'(key_valid), 32'h0);
        go_to(96);
        r_keys = '0;
        go_to(127); chk("s2_held_late", 32'(key_held), 32'h1);
        go_to(128);
        chk("s2_held_clear", 32'(key_held), 32'h0);
        chk("s2_code_hold",  32'(key_code), 32'h6);
        chk("s2_pulses", 32'(n_pulses - p0), 32'd1);

        // 3: bounce on r3c0 (0): 1 scan on, 1 off, 3 on
        do_reset();
        r_keys = 16'h1000;
        go_to(16);  r_keys = '0;
        go_to(32);  r_keys = 16'h1000;
        go_to(63);  chk("s3_no_early", 32'(n_pulses - p0), 32'd0);
        go_to(64);
        chk("s3_valid", 32'(key_valid), 32'h1);
        chk("s3_code",  32'(key_code), 32'h0);
        chk("s3_held",  32'(key_held), 32'h1);
        go_to(80);  r_keys = '0;
        chk("s3_pulses", 32'(n_pulses - p0), 32'd1);

        // 4: r0c0 + r0c3 together, then r0c3 released
        do_reset();
        r_keys = 16'h0009;
        go_to(64);
        chk("s4_multi_pulses", 32'(n_pulses - p0), 32'd0);
        chk("s4_multi_held",   32'(key_held), 32'h0);
        r_keys = 16'h0001;
        go_to(95);  chk("s4_valid_early", 32'(key_valid), 32'h0);
        go_to(96);
        chk("s4_valid", 32'(key_valid), 32'h1);
        chk("s4_code",  32'(key_code), 32'h1);
        r_keys = '0;

        // 5: key 9 (r2c2), one NONE scan while pressed, then back
        do_reset();
        r_keys = 16'h0400;
        go_to(32);
        chk("s5_valid", 32'(key_valid), 32'h1);
        chk("s5_code",  32'(key_code), 32'h9);
        r_keys = '0;
        go_to(48);  chk("s5_held_gap", 32'(key_held), 32'h1);
        r_keys = 16'h0400;
        go_to(64);
        chk("s5_no_repulse", 32'(key_valid), 32'h0);
        chk("s5_held_back",  32'(key_held), 32'h1);
        go_to(96);
        chk("s5_pulses", 32'(n_pulses - p0), 32'd1);
        chk("s5_code_end", 32'(key_code), 32'h9);
        r_keys = '0;

        // 6: reset during a held key A (r0c3)
        do_reset();
        r_keys = 16'h0008;
        go_to(32);
        chk("s6_valid", 32'(key_valid), 32'h1);
        chk("s6_code",  32'(key_code), 32'hA);
        go_to(40);
        chk("s6_held_pre", 32'(key_held), 32'h1);
        reset = 1'b1;
        #1;
        chk("s6_rst_col",   32'(col), 32'hE);
        chk("s6_rst_code",  32'(key_code), 32'h0);
        chk("s6_rst_valid", 32'(key_valid), 32'h0);
        chk("s6_rst_held",  32'(key_held), 32'h0);
        repeat (2) @(negedge orig_clk);
        reset = 1'b0;
        cyc = 0;
        p0 = n_pulses;
        go_to(31);  chk("s6_re_early", 32'(key_valid), 32'h0);
        go_to(32);
        chk("s6_re_valid", 32'(key_valid), 32'h1);
        chk("s6_re_code",  32'(key_code), 32'hA);
        chk("s6_re_held",  32'(key_held), 32'h1);
        r_keys = '0;
        go_to(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
